// File: rtl/fib_pkg.sv
// ----------------------------------------------------------------------------
// fib_pkg
// Shared types and constants for the sequential Fibonacci generator.
//   fib_state_e : controller state encoding (IDLE, CALC, DONE)
//   FIB_F0/F1   : seed terms loaded into the datapath on an accepted start
//   FIB_REF     : F(0..15), handy for checking the generator from benches
//   fib_ref_lookup : table lookup helper for FIB_REF
// ----------------------------------------------------------------------------
package fib_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } fib_state_e;

   localparam int unsigned FIB_F0 = 0;
   localparam int unsigned FIB_F1 = 1;

   localparam int unsigned FIB_REF_N = 16;

   localparam int unsigned FIB_REF [FIB_REF_N] = '{
      0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610
   };

   function automatic int unsigned fib_ref_lookup(input int unsigned idx);
      int unsigned res;
      res = 0;
      if (idx < FIB_REF_N) begin
         res = FIB_REF[idx];
      end
      return res;
   endfunction

endpackage : fib_pkg

// File: rtl/fib_gen.sv
// ----------------------------------------------------------------------------
// fib_gen
// Iterative Fibonacci generator: maps an index n to F(n) mod 2^VAL_W, one
// addition per clock, with a start/busy/done handshake.
//
// Ports
//   clk    : system clock, all state updates on posedge
//   rst    : synchronous active-high reset
//   start  : request, sampled only while idle
//   n      : index, latched on an accepted start
//   busy   : high in CALC and DONE
//   done   : one-cycle pulse, fib/ovf just updated
//   fib    : F(n) mod 2^VAL_W, held until the next done
//   ovf    : F(n) did not fit in VAL_W bits, held with fib
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; fib/ovf hold the previous result
// CALC  | one step per cycle while cnt != 0, result captured when cnt == 0
// DONE  | done pulse cycle; returns to IDLE, start ignored here
// ----------------------------------------------------------------------------
module fib_gen
   import fib_pkg::*;
#(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned VAL_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] n,
   output logic             busy,
   output logic             done,
   output logic [VAL_W-1:0] fib,
   output logic             ovf
);

   fib_state_e       state_q, state_d;
   logic [IDX_W-1:0] cnt_q,   cnt_d;
   logic [VAL_W-1:0] a_q,     a_d;
   logic [VAL_W-1:0] b_q,     b_d;
   logic             a_ovf_q, a_ovf_d;
   logic             b_ovf_q, b_ovf_d;
   logic [VAL_W-1:0] fib_q,   fib_d;
   logic             ovf_q,   ovf_d;

   // One bit wider than the terms so the top bit is the carry out.
   logic [VAL_W:0]   sum;

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      a_ovf_d = a_ovf_q;
      b_ovf_d = b_ovf_q;
      fib_d   = fib_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d   = n;
               a_d     = VAL_W'(FIB_F0);
               b_d     = VAL_W'(FIB_F1);
               a_ovf_d = 1'b0;
               b_ovf_d = 1'b0;
               state_d = ST_CALC;
            end
         end

         ST_CALC: begin
            if (cnt_q != '0) begin
               a_d     = b_q;
               b_d     = sum[VAL_W-1:0];
               a_ovf_d = b_ovf_q;
               // Once a term has wrapped every later term is also too big,
               // so the flag is sticky along the sequence.
               b_ovf_d = sum[VAL_W] | a_ovf_q | b_ovf_q;
               cnt_d   = cnt_q - 1'b1;
            end else begin
               // a holds F(n); b is only a look-ahead term, so its overflow
               // never reaches ovf.
               fib_d   = a_q;
               ovf_d   = a_ovf_q;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         a_ovf_q <= 1'b0;
         b_ovf_q <= 1'b0;
         fib_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         a_ovf_q <= a_ovf_d;
         b_ovf_q <= b_ovf_d;
         fib_q   <= fib_d;
         ovf_q   <= ovf_d;
      end
   end

   // Decoded straight from the state register, so no combinational glitches.
   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign fib  = fib_q;
   assign ovf  = ovf_q;

endmodule : fib_gen

// File: tb/tb_fib_gen.sv
// ----------------------------------------------------------------------------
// tb_fib_gen
// Two generators (16-bit and 8-bit results) driven by the same stimulus.
// The driver predicts each accepted request and queues the expected result;
// per-instance monitors compare busy/done/fib/ovf on every falling edge.
// ----------------------------------------------------------------------------
module tb_fib_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] n = '0;

   logic        busy16, done16, ovf16;
   logic [15:0] fib16;
   logic        busy8, done8, ovf8;
   logic [7:0]  fib8;

   always #5 clk = ~clk;

   fib_gen #(.IDX_W(4), .VAL_W(16)) u_dut16 (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .n     (n),
      .busy  (busy16),
      .done  (done16),
      .fib   (fib16),
      .ovf   (ovf16)
   );

   fib_gen #(.IDX_W(4), .VAL_W(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .n     (n),
      .busy  (busy8),
      .done  (done8),
      .fib   (fib8),
      .ovf   (ovf8)
   );

   typedef struct {
      logic [15:0] fib;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int busy_from = 0;
   int busy_to = -1;
   int free_at = 0;
   bit mon_en = 1'b0;

   logic [15:0] last16_fib = '0;
   logic        last16_ovf = 1'b0;
   logic [15:0] last8_fib = '0;
   logic        last8_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Fibonacci by plain arithmetic, wide enough never to wrap for n <= 15.
   function automatic longint fib_true(input int k);
      longint fa, fb, ft;
      fa = 0;
      fb = 1;
      for (int i = 0; i < k; i++) begin
         ft = fa + fb;
         fa = fb;
         fb = ft;
      end
      return fa;
   endfunction

   function automatic exp_t make_exp(input int k, input int w, input int due);
      exp_t   e;
      longint f;
      f     = fib_true(k);
      e.fib = 16'(f % (64'sd1 <<< w));
      e.ovf = (f >= (64'sd1 <<< w));
      e.cyc = due;
      return e;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
      end
   endtask

   function automatic bit busy_exp();
      return (cyc >= busy_from) && (cyc <= busy_to);
   endfunction

   // Advance one clock and apply the request rules to what the DUTs sampled.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst) begin
         q16.delete();
         q8.delete();
         last16_fib = '0;
         last16_ovf = 1'b0;
         last8_fib  = '0;
         last8_ovf  = 1'b0;
         busy_to    = -1;
         free_at    = cyc + 1;
         mon_en     = 1'b1;
      end else if (start && cyc >= free_at) begin
         q16.push_back(make_exp(int'(n), 16, cyc + int'(n) + 1));
         q8.push_back(make_exp(int'(n), 8, cyc + int'(n) + 1));
         busy_from = cyc;
         busy_to   = cyc + int'(n) + 1;
         free_at   = cyc + int'(n) + 3;
      end
   endtask

   task automatic wait_free();
      start = 1'b0;
      while (cyc + 1 < free_at) step();
   endtask

   task automatic run_one(input int k);
      wait_free();
      start = 1'b1;
      n     = 4'(k);
      step();
      start = 1'b0;
      n     = 4'($urandom);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         bit   ed;
         while (q16.size() > 0 && q16[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_done16 cyc=%0d actual=none required=done at %0d", cyc, q16[0].cyc);
            void'(q16.pop_front());
         end
         ed = (q16.size() > 0) && (q16[0].cyc == cyc);
         chk("busy16", busy16, busy_exp());
         chk("done16", done16, ed);
         if (ed) begin
            e = q16.pop_front();
            chk("fib16", fib16, e.fib);
            chk("ovf16", ovf16, e.ovf);
            last16_fib = e.fib;
            last16_ovf = e.ovf;
         end else begin
            chk("hold_fib16", fib16, last16_fib);
            chk("hold_ovf16", ovf16, last16_ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         bit   ed;
         while (q8.size() > 0 && q8[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_done8 cyc=%0d actual=none required=done at %0d", cyc, q8[0].cyc);
            void'(q8.pop_front());
         end
         ed = (q8.size() > 0) && (q8[0].cyc == cyc);
         chk("busy8", busy8, busy_exp());
         chk("done8", done8, ed);
         if (ed) begin
            e = q8.pop_front();
            chk("fib8", fib8, e.fib[7:0]);
            chk("ovf8", ovf8, e.ovf);
            last8_fib = e.fib;
            last8_ovf = e.ovf;
         end else begin
            chk("hold_fib8", fib8, last8_fib[7:0]);
            chk("hold_ovf8", ovf8, last8_ovf);
         end
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      n     = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // n = 0: shortest run
      run_one(0);

      // n = 7, with a start for n = 3 while busy that must be ignored
      run_one(7);
      step();
      step();
      start = 1'b1;
      n     = 4'd3;
      step();
      start = 1'b0;

      // back-to-back sweep over every index
      for (int k = 0; k < 16; k++) run_one(k);

      // 8-bit wrap boundary and per-run ovf clearing
      run_one(13);
      run_one(14);
      run_one(2);

      // reset in the middle of a long run
      run_one(15);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      run_one(5);

      // start held high: one accepted request every n+3 cycles
      wait_free();
      start = 1'b1;
      n     = 4'd4;
      repeat (30) step();
      start = 1'b0;

      // random requests, index changes and occasional resets
      for (int i = 0; i < 300; i++) begin
         start = ($urandom_range(0, 2) == 0);
         n     = 4'($urandom);
         rst   = ($urandom_range(0, 60) == 0);
         step();
      end
      rst   = 1'b0;
      start = 1'b0;

      for (int i = 0; i < 40 && (q16.size() > 0 || q8.size() > 0); i++) step();
      step();
      if (q16.size() > 0 || q8.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain actual=%0d/%0d pending required=0", q16.size(), q8.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_fib_gen
